// File: rtl/anim_pkg.sv
// Shared types and defaults for the frame-ROM animation playback path.
package anim_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAYING,
    PAUSED,
    DONE
  } anim_state_t;

  localparam int DEF_NUM_FRAMES = 21;
  localparam int DEF_IDX_W      = 5;
  localparam int DEF_TICK_DIV   = 1048576;
  localparam int DEF_SPEED_W    = 3;

  // Colour the frame-select mux drives while frameValid is low.
  localparam logic [11:0] BLANK_COLOR = 12'hFFF;

endpackage

// File: rtl/frame_tick_gen.sv
// Base-tick divider followed by a speed prescaler; pulses once per speed+1 base ticks.
module frame_tick_gen
  import anim_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int SPEED_W  = DEF_SPEED_W
) (
  input  logic               vgaClk,
  input  logic               resetN,
  input  logic               en,
  input  logic               clr,
  input  logic [SPEED_W-1:0] speed,
  output logic               advPulse
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0]   baseCnt;
  logic [SPEED_W-1:0] prescale;
  logic               baseTick;

  assign baseTick = en && !clr && (baseCnt == CNT_MAX);
  assign advPulse = baseTick && (prescale == speed);

  // A prescaler left above a newly lowered speed falls back to 0 on the next tick.
  always_ff @(posedge vgaClk or negedge resetN) begin
    if (!resetN) begin
      baseCnt  <= '0;
      prescale <= '0;
    end else if (clr) begin
      baseCnt  <= '0;
      prescale <= '0;
    end else if (en) begin
      if (baseTick) begin
        baseCnt  <= '0;
        prescale <= (prescale >= speed) ? '0 : prescale + 1'b1;
      end else begin
        baseCnt <= baseCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/animation_sequencer.sv
// Playback controller choosing the frame index; index changes commit only on a vblank rising edge.
module animation_sequencer
  import anim_pkg::*;
#(
  parameter int NUM_FRAMES = DEF_NUM_FRAMES,
  parameter int IDX_W      = DEF_IDX_W,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int SPEED_W    = DEF_SPEED_W
) (
  input  logic               vgaClk,
  input  logic               resetN,
  input  logic               vblank,
  input  logic               play,
  input  logic               stepReq,
  input  logic               restart,
  input  logic               loopEn,
  input  logic [SPEED_W-1:0] speed,
  output logic [IDX_W-1:0]   frameIdx,
  output logic               frameValid,
  output logic               busy,
  output logic               donePulse
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FRAMES - 1);

  anim_state_t      state, nextState;
  logic             vblankD, vbEdge, commit;
  logic             pendValid;
  logic [IDX_W-1:0] pendIdx, base, nextIdx;
  logic             canAdv, doneArmed, goDone, restartAct, loadZero;
  logic             tickEn, tickClr, tickAdv, advReq, advTake;

  assign vbEdge     = vblank && !vblankD;
  assign commit     = vbEdge && pendValid;
  assign restartAct = restart && (state != IDLE);
  assign goDone     = commit && doneArmed && !restartAct;
  assign busy       = (state == PLAYING);

  // Next index is taken from the pending slot when one exists, so a same-cycle commit chains correctly.
  always_comb begin
    base    = pendValid ? pendIdx : frameIdx;
    nextIdx = base + 1'b1;
    canAdv  = 1'b1;
    if (base == LAST_IDX) begin
      nextIdx = '0;
      canAdv  = loopEn;
    end
  end

  always_comb begin
    nextState = state;
    loadZero  = 1'b0;
    if (restartAct) begin
      nextState = play ? PLAYING : PAUSED;
      loadZero  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (play) begin
            nextState = PLAYING;
            loadZero  = 1'b1;
          end
        end
        PLAYING: begin
          if (goDone)     nextState = DONE;
          else if (!play) nextState = PAUSED;
        end
        PAUSED: begin
          if (goDone)    nextState = DONE;
          else if (play) nextState = PLAYING;
        end
        DONE: nextState = DONE;
        default: nextState = IDLE;
      endcase
    end
  end

  assign tickEn  = (state == PLAYING);
  assign tickClr = restartAct || ((state != PLAYING) && (nextState == PLAYING));

  frame_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .SPEED_W  (SPEED_W)
  ) u_tick (
    .vgaClk   (vgaClk),
    .resetN   (resetN),
    .en       (tickEn),
    .clr      (tickClr),
    .speed    (speed),
    .advPulse (tickAdv)
  );

  // Only one pending index is held; a request arriving while it is occupied is dropped.
  assign advReq  = ((state == PLAYING) && tickAdv) || ((state == PAUSED) && stepReq);
  assign advTake = advReq && canAdv && !restartAct && !goDone && (!pendValid || commit);

  always_ff @(posedge vgaClk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      vblankD   <= 1'b0;
      donePulse <= 1'b0;
    end else begin
      state     <= nextState;
      vblankD   <= vblank;
      donePulse <= goDone;
    end
  end

  always_ff @(posedge vgaClk or negedge resetN) begin
    if (!resetN) begin
      frameIdx   <= '0;
      frameValid <= 1'b0;
      pendValid  <= 1'b0;
      pendIdx    <= '0;
      doneArmed  <= 1'b0;
    end else begin
      if (commit) begin
        frameIdx   <= pendIdx;
        frameValid <= 1'b1;
      end
      if (loadZero) begin
        pendValid <= 1'b1;
        pendIdx   <= '0;
      end else if (advTake) begin
        pendValid <= 1'b1;
        pendIdx   <= nextIdx;
      end else if (commit) begin
        pendValid <= 1'b0;
      end
      if (loadZero || goDone)
        doneArmed <= 1'b0;
      else if (advTake && !loopEn && (nextIdx == LAST_IDX))
        doneArmed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_animation_sequencer.sv
// Bench for animation_sequencer: directed vector table plus randomized run against a reference model.
module tb_animation_sequencer;

  localparam int NF        = 4;
  localparam int IW        = 2;
  localparam int TD        = 4;
  localparam int SW        = 3;
  localparam int VB_PERIOD = 40;
  localparam int VB_HIGH   = 3;

  localparam int M_IDLE  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic          vgaClk = 1'b0;
  logic          resetN, vblank, play, stepReq, restart, loopEn;
  logic [SW-1:0] speed;
  logic [IW-1:0] frameIdx;
  logic          frameValid, busy, donePulse;

  always #5 vgaClk = ~vgaClk;

  animation_sequencer #(
    .NUM_FRAMES (NF),
    .IDX_W      (IW),
    .TICK_DIV   (TD),
    .SPEED_W    (SW)
  ) dut (
    .vgaClk     (vgaClk),
    .resetN     (resetN),
    .vblank     (vblank),
    .play       (play),
    .stepReq    (stepReq),
    .restart    (restart),
    .loopEn     (loopEn),
    .speed      (speed),
    .frameIdx   (frameIdx),
    .frameValid (frameValid),
    .busy       (busy),
    .donePulse  (donePulse)
  );

  int checks   = 0;
  int errors   = 0;
  int vbPhase  = 0;
  int doneSeen = 0;

  // Reference model: mode, shown frame, one pending slot (-1 = empty), cycle and tick counts.
  int mMode, mFrame, mValid, mPend, mArmed, mCnt, mPre, mVbPrev, mDone;

  typedef struct {
    string name;
    bit    play;
    bit    loopEn;
    bit    restartP;
    int    stepPulses;
    int    edges;
    int    expIdx;
    int    expValid;
    int    expBusy;
    int    expDone;
  } vec_t;

  vec_t vecs[$];

  function automatic void modelReset();
    mMode = M_IDLE; mFrame = 0; mValid = 0; mPend = -1; mArmed = 0;
    mCnt = 0; mPre = 0; mVbPrev = 0; mDone = 0;
  endfunction

  function automatic void modelStep();
    bit edgeNow, commitNow, restartAct, tickAdv, slotFree, goDone, nextOk, req;
    int base, nextVal, oldMode, oldPend;
    oldMode    = mMode;
    oldPend    = mPend;
    edgeNow    = vblank && !mVbPrev;
    mVbPrev    = vblank;
    commitNow  = edgeNow && (oldPend >= 0);
    restartAct = restart && (oldMode != M_IDLE);
    tickAdv    = 0;
    if (oldMode == M_PLAY) begin
      mCnt++;
      if (mCnt == TD) begin
        mCnt = 0;
        if (mPre == int'(speed)) begin tickAdv = 1; mPre = 0; end
        else if (mPre > int'(speed)) mPre = 0;
        else mPre++;
      end
    end
    base = (oldPend >= 0) ? oldPend : mFrame;
    if (base < NF - 1) begin nextOk = 1; nextVal = base + 1; end
    else begin nextOk = loopEn; nextVal = 0; end
    slotFree = (oldPend < 0) || commitNow;
    goDone   = commitNow && (mArmed != 0) && !restartAct;
    mDone    = goDone;
    if (commitNow) begin mFrame = oldPend; mValid = 1; mPend = -1; end
    if (restartAct) begin
      mPend = 0; mArmed = 0; mCnt = 0; mPre = 0;
      mMode = play ? M_PLAY : M_PAUSE;
    end else if (oldMode == M_IDLE) begin
      if (play) begin mPend = 0; mMode = M_PLAY; mCnt = 0; mPre = 0; end
    end else if (goDone) begin
      mMode = M_DONE; mArmed = 0;
    end else if (oldMode != M_DONE) begin
      req = ((oldMode == M_PAUSE) && stepReq) || ((oldMode == M_PLAY) && tickAdv);
      if (req && slotFree && nextOk) begin
        mPend = nextVal;
        if (!loopEn && nextVal == NF - 1) mArmed = 1;
      end
      if (oldMode == M_PLAY && !play) mMode = M_PAUSE;
      if (oldMode == M_PAUSE && play) begin mMode = M_PLAY; mCnt = 0; mPre = 0; end
    end
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      if (errors <= 40)
        $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkModel();
    checkOutput("model frameIdx",   int'(frameIdx),   mFrame);
    checkOutput("model frameValid", int'(frameValid), mValid);
    checkOutput("model busy",       int'(busy),       (mMode == M_PLAY) ? 1 : 0);
    checkOutput("model donePulse",  int'(donePulse),  mDone);
  endtask

  // One clock: drive vblank from the phase counter, step the model at the edge, check at negedge.
  task automatic applyStimulus();
    vblank = (vbPhase % VB_PERIOD) < VB_HIGH;
    @(posedge vgaClk);
    if (!resetN) modelReset();
    else modelStep();
    vbPhase++;
    @(negedge vgaClk);
    if (donePulse) doneSeen++;
    checkModel();
  endtask

  task automatic runEdges(input int n);
    int seen = 0;
    while (seen < n) begin
      bit isEdge = (vbPhase % VB_PERIOD) == 0;
      applyStimulus();
      if (isEdge) seen++;
    end
  endtask

  task automatic runRow(input vec_t v);
    int pulses = v.stepPulses;
    play   = v.play;
    loopEn = v.loopEn;
    if (v.restartP && pulses == 0) pulses = 1;
    for (int p = 0; p < pulses; p++) begin
      restart = v.restartP && (p == 0);
      stepReq = (p < v.stepPulses);
      applyStimulus();
      restart = 1'b0;
      stepReq = 1'b0;
      repeat (3) applyStimulus();
    end
    runEdges(v.edges);
    checkOutput({v.name, " frameIdx"},   int'(frameIdx),   v.expIdx);
    checkOutput({v.name, " frameValid"}, int'(frameValid), v.expValid);
    checkOutput({v.name, " busy"},       int'(busy),       v.expBusy);
    checkOutput({v.name, " doneCount"},  doneSeen,         v.expDone);
  endtask

  function automatic void addVec(input string n, input bit pl, input bit lp, input bit rs,
                                 input int st, input int ed, input int ei, input int ev,
                                 input int eb, input int ed2);
    vec_t v;
    v.name = n; v.play = pl; v.loopEn = lp; v.restartP = rs; v.stepPulses = st;
    v.edges = ed; v.expIdx = ei; v.expValid = ev; v.expBusy = eb; v.expDone = ed2;
    vecs.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //     name                 play loop rst step edges idx valid busy done
    addVec("loop f0",            1, 1, 0, 0, 1, 0, 1, 1, 0);
    addVec("loop f1",            1, 1, 0, 0, 1, 1, 1, 1, 0);
    addVec("loop f2",            1, 1, 0, 0, 1, 2, 1, 1, 0);
    addVec("loop f3",            1, 1, 0, 0, 1, 3, 1, 1, 0);
    addVec("loop wrap",          1, 1, 0, 0, 1, 0, 1, 1, 0);
    addVec("loop f1 again",      1, 1, 0, 0, 1, 1, 1, 1, 0);
    addVec("restart to pause",   0, 1, 1, 0, 1, 0, 1, 0, 0);
    addVec("step to 1",          0, 1, 0, 1, 1, 1, 1, 0, 0);
    addVec("step to 2",          0, 1, 0, 1, 1, 2, 1, 0, 0);
    addVec("step to 3",          0, 1, 0, 1, 1, 3, 1, 0, 0);
    addVec("step wrap",          0, 1, 0, 1, 1, 0, 1, 0, 0);
    addVec("paused hold",        0, 1, 0, 0, 1, 0, 1, 0, 0);
    addVec("step to 1 again",    0, 1, 0, 1, 1, 1, 1, 0, 0);
    addVec("double step",        0, 1, 0, 2, 1, 2, 1, 0, 0);
    addVec("second step drop",   0, 1, 0, 0, 1, 2, 1, 0, 0);
    addVec("oneshot f0",         1, 0, 1, 0, 1, 0, 1, 1, 0);
    addVec("oneshot f1",         1, 0, 0, 0, 1, 1, 1, 1, 0);
    addVec("oneshot f2",         1, 0, 0, 0, 1, 2, 1, 1, 0);
    addVec("oneshot last",       1, 0, 0, 0, 1, 3, 1, 0, 1);
    addVec("done hold",          1, 0, 0, 0, 2, 3, 1, 0, 1);
    addVec("done ignores step",  1, 0, 0, 1, 1, 3, 1, 0, 1);
    addVec("done ignores loop",  1, 1, 0, 0, 1, 3, 1, 0, 1);
    addVec("restart from done",  1, 1, 1, 0, 1, 0, 1, 1, 1);
    addVec("resume after done",  1, 1, 0, 0, 1, 1, 1, 1, 1);
    addVec("restart pause 2",    0, 1, 1, 0, 1, 0, 1, 0, 1);
    addVec("step to 1 b",        0, 1, 0, 1, 1, 1, 1, 0, 1);
    addVec("restart beats step", 0, 1, 1, 1, 1, 0, 1, 0, 1);
    addVec("after restart hold", 0, 1, 0, 0, 1, 0, 1, 0, 1);
    addVec("replay f0",          1, 1, 1, 0, 1, 0, 1, 1, 1);
    addVec("replay f1",          1, 1, 0, 0, 1, 1, 1, 1, 1);
    addVec("replay f2",          1, 1, 0, 0, 1, 2, 1, 1, 1);

    resetN = 1'b0; vblank = 1'b0; play = 1'b0; stepReq = 1'b0;
    restart = 1'b0; loopEn = 1'b1; speed = '0;
    modelReset();
    repeat (5) applyStimulus();
    resetN = 1'b1;
    checkOutput("reset frameIdx",   int'(frameIdx),   0);
    checkOutput("reset frameValid", int'(frameValid), 0);
    checkOutput("reset busy",       int'(busy),       0);
    checkOutput("reset donePulse",  int'(donePulse),  0);

    foreach (vecs[i]) runRow(vecs[i]);

    // Let a pending index load mid-play, then pull reset between clock edges.
    repeat (6) applyStimulus();
    #2 resetN = 1'b0;
    #1;
    modelReset();
    checkOutput("async rst frameIdx",   int'(frameIdx),   0);
    checkOutput("async rst frameValid", int'(frameValid), 0);
    checkOutput("async rst busy",       int'(busy),       0);
    checkOutput("async rst donePulse",  int'(donePulse),  0);
    play = 1'b0;
    repeat (3) applyStimulus();
    resetN = 1'b1;
    runEdges(1);
    checkOutput("post rst idle frameValid", int'(frameValid), 0);
    checkOutput("post rst idle frameIdx",   int'(frameIdx),   0);
    play = 1'b1;
    runEdges(1);
    checkOutput("post rst play frameValid", int'(frameValid), 1);
    checkOutput("post rst play frameIdx",   int'(frameIdx),   0);
    checkOutput("post rst play busy",       int'(busy),       1);

    // Randomized run checked cycle by cycle against the model.
    resetN = 1'b0;
    repeat (3) applyStimulus();
    resetN = 1'b1;
    play = 1'b1; loopEn = 1'b1; speed = '0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 63) == 0)  play = ~play;
      if ($urandom_range(0, 127) == 0) loopEn = ~loopEn;
      if ($urandom_range(0, 199) == 0) speed = SW'($urandom_range(0, 3));
      stepReq = ($urandom_range(0, 7) == 0);
      restart = ($urandom_range(0, 149) == 0);
      applyStimulus();
    end
    stepReq = 1'b0;
    restart = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
